park_gate_controller: RTL
=========================

# park_gate_controller

Sequencer for the parking-lot datapath. It owns the 8-slot occupancy register and the secret 3-bit pattern, and arbitrates between entry and exit requests. On entry it issues an encrypted token (slot XOR pattern). On exit it decrypts the presented token with an internal `decrypt` instance and frees the slot. It then drives the gate for a fixed open time. It sits between the entry/exit kiosks and the gate actuator.

## Interface
Parameters:
- `GATE_CYCLES`, default 4: cycles `gate_open` stays high per accepted vehicle; legal range 1–15.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: reset, synchronous, active-low.
- `pattern_load` in 1: request to load `pattern_in` as the secret pattern.
- `pattern_in` in 3: new pattern value.
- `entry_req` in 1: level request from the entry kiosk; held high until `entry_ack` or `entry_full`.
- `exit_req` in 1: level request from the exit kiosk; held high until `exit_ack` or `exit_err`.
- `exit_token` in 3: token presented at exit; stable while `exit_req` is high.
- `entry_ack` out 1: one-cycle pulse; a slot was allocated.
- `entry_token` out 3: token for the last allocated slot; holds its value until the next `entry_ack`.
- `entry_full` out 1: one-cycle pulse; entry denied because no slot is free.
- `exit_ack` out 1: one-cycle pulse; the token was valid and its slot was freed.
- `exit_err` out 1: one-cycle pulse; the token decrypts to an unoccupied slot.
- `gate_open` out 1: gate actuator drive.
- `occupancy` out 8: bit i = 1 means slot i is occupied.
- `free_count` out 4: number of free slots, computed as 8 − popcount(`occupancy`), range 0–8.
- `busy` out 1: high in every state except IDLE.

## Operation
- Reset values:
  - `occupancy` = 0, `free_count` = 8, pattern = 3'b000, `entry_token` = 0.
  - All pulses = 0, `gate_open` = 0, `busy` = 0, state = IDLE.
- States: IDLE, ENTRY, EXIT, GATE.
- IDLE:
  - Samples inputs only when no response pulse is high in the current cycle.
  - Priority: `exit_req` > `entry_req` > `pattern_load`.
  - On `exit_req`: latch `exit_token`, go to EXIT.
  - On `entry_req`: go to ENTRY.
  - On `pattern_load` with `occupancy` = 0: pattern ← `pattern_in`, stay IDLE.
  - `pattern_load` with any slot occupied is ignored, with no side effect.
- ENTRY:
  - If a free slot exists: allocate the lowest-index free slot s, set `occupancy`[s], set `entry_token` ← s XOR pattern, pulse `entry_ack`, go to GATE.
  - Otherwise: pulse `entry_full`, go to IDLE.
- EXIT:
  - Compute p = `decrypt`(latched token, pattern).
  - If `occupancy`[p] = 1: clear it, pulse `exit_ack`, go to GATE.
  - Otherwise: pulse `exit_err`, go to IDLE.
- GATE: `gate_open` = 1; a down-counter is loaded with `GATE_CYCLES`; return to IDLE when it expires. Requests arriving during GATE are not sampled.
- Outputs are registered; `occupancy`, `free_count` and the pulses all change on the same edge.

## Timing
- Cycle 0: request high while in IDLE. Edge 0: state ← ENTRY or EXIT.
- Edge 1: response registered. Cycle 2: pulse visible; on success `gate_open` also goes high in cycle 2.
- `gate_open` is high for exactly `GATE_CYCLES` cycles (cycles 2 … 1+G). IDLE is reached in cycle 2+G; a new request is sampled there.
- Failure path: the pulse is in cycle 2 with state already IDLE. The request is ignored in cycle 2 and re-sampled in cycle 3 if still high.
- Simultaneous `entry_req` and `exit_req`: exit is served first; entry is served after the exit's GATE period.
- `rst_n` low mid-operation: at the next edge, every output returns to its reset value, the gate closes, and any in-flight request is dropped.
- Full lot: `entry_full` when `free_count` = 0. Empty lot: every exit yields `exit_err`.

## Test plan
- Reset, then load pattern 3'b101. Entry → `entry_ack` in cycle 2, `entry_token` = 3'b101, `occupancy` = 8'h01, `gate_open` high for 4 cycles.
- Second entry → `entry_token` = 3'b100, `occupancy` = 8'h03, `free_count` = 6. Exit with token 3'b100 → `exit_ack`, `occupancy` = 8'h01. Repeat the same token → `exit_err`, `occupancy` unchanged.
- Eight entries fill the lot (`occupancy` = 8'hFF, `free_count` = 0). A ninth entry → `entry_full`, no gate. One exit, then entry → reuses the freed slot (lowest index).
- `entry_req` and `exit_req` rise in the same cycle with a valid token → `exit_ack` first. `entry_ack` arrives 2+`GATE_CYCLES` cycles later.
- `pattern_load` with 3'b011 while `occupancy` ≠ 0 → pattern unchanged; subsequent tokens still use 3'b101.
- `rst_n` low in the second cycle of GATE → next cycle `gate_open` = 0, `occupancy` = 0, pattern = 0, `busy` = 0.

Source files
------------

// File: rtl/park_gate_controller.sv
// Parking-lot sequencer: slot allocation, token encrypt/decrypt and timed gate drive.
// decrypt recovers the slot index from an exit token.

module decrypt (
    input  logic [2:0] token,
    input  logic [2:0] pattern,
    output logic [2:0] slot
);
    assign slot = token ^ pattern;
endmodule

module park_gate_controller #(
    parameter int unsigned GATE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       pattern_load,
    input  logic [2:0] pattern_in,
    input  logic       entry_req,
    input  logic       exit_req,
    input  logic [2:0] exit_token,
    output logic       entry_ack,
    output logic [2:0] entry_token,
    output logic       entry_full,
    output logic       exit_ack,
    output logic       exit_err,
    output logic       gate_open,
    output logic [7:0] occupancy,
    output logic [3:0] free_count,
    output logic       busy
);
    localparam int unsigned SLOTS = 8;
    localparam int unsigned SW    = 3;
    localparam int unsigned CW    = 4;

    typedef enum logic [1:0] {IDLE, ENTRY, EXIT, GATE} state_t;

    state_t          state, state_d;
    logic [SW-1:0]   pattern, pattern_d;
    logic [SW-1:0]   tok_q, tok_d;
    logic [CW-1:0]   cnt, cnt_d;
    logic [SLOTS-1:0] occ_d;
    logic [SW-1:0]   etok_d;
    logic [CW-1:0]   free_d;
    logic            entry_ack_d, entry_full_d, exit_ack_d, exit_err_d;
    logic            gate_d, busy_d;
    logic            resp_c;
    logic            has_free_c;
    logic [SW-1:0]   free_idx_c;
    logic [SW-1:0]   slot_dec_c;

    decrypt u_decrypt (
        .token   (tok_q),
        .pattern (pattern),
        .slot    (slot_dec_c)
    );

    // Lowest-index free slot.
    always_comb begin
        has_free_c = ~&occupancy;
        free_idx_c = '0;
        for (int i = SLOTS - 1; i >= 0; i--) begin
            if (!occupancy[i]) free_idx_c = SW'(i);
        end
    end

    always_comb begin
        state_d      = state;
        pattern_d    = pattern;
        tok_d        = tok_q;
        cnt_d        = cnt;
        occ_d        = occupancy;
        etok_d       = entry_token;
        entry_ack_d  = 1'b0;
        entry_full_d = 1'b0;
        exit_ack_d   = 1'b0;
        exit_err_d   = 1'b0;
        free_d       = '0;
        resp_c       = entry_ack | entry_full | exit_ack | exit_err;

        case (state)
            IDLE: begin
                if (!resp_c) begin
                    if (exit_req) begin
                        tok_d   = exit_token;
                        state_d = EXIT;
                    end else if (entry_req) begin
                        state_d = ENTRY;
                    end else if (pattern_load && occupancy == '0) begin
                        pattern_d = pattern_in;
                    end
                end
            end
            ENTRY: begin
                if (has_free_c) begin
                    occ_d[free_idx_c] = 1'b1;
                    etok_d            = free_idx_c ^ pattern;
                    entry_ack_d       = 1'b1;
                    cnt_d             = CW'(GATE_CYCLES);
                    state_d           = GATE;
                end else begin
                    entry_full_d = 1'b1;
                    state_d      = IDLE;
                end
            end
            EXIT: begin
                if (occupancy[slot_dec_c]) begin
                    occ_d[slot_dec_c] = 1'b0;
                    exit_ack_d        = 1'b1;
                    cnt_d             = CW'(GATE_CYCLES);
                    state_d           = GATE;
                end else begin
                    exit_err_d = 1'b1;
                    state_d    = IDLE;
                end
            end
            GATE: begin
                if (cnt <= CW'(1)) state_d = IDLE;
                else               cnt_d   = cnt - CW'(1);
            end
            default: state_d = IDLE;
        endcase

        gate_d = (state_d == GATE);
        busy_d = (state_d != IDLE);

        free_d = CW'(SLOTS);
        for (int i = 0; i < SLOTS; i++) begin
            free_d = free_d - CW'(occ_d[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            pattern     <= '0;
            tok_q       <= '0;
            cnt         <= '0;
            occupancy   <= '0;
            free_count  <= CW'(SLOTS);
            entry_token <= '0;
            entry_ack   <= 1'b0;
            entry_full  <= 1'b0;
            exit_ack    <= 1'b0;
            exit_err    <= 1'b0;
            gate_open   <= 1'b0;
            busy        <= 1'b0;
        end else begin
            state       <= state_d;
            pattern     <= pattern_d;
            tok_q       <= tok_d;
            cnt         <= cnt_d;
            occupancy   <= occ_d;
            free_count  <= free_d;
            entry_token <= etok_d;
            entry_ack   <= entry_ack_d;
            entry_full  <= entry_full_d;
            exit_ack    <= exit_ack_d;
            exit_err    <= exit_err_d;
            gate_open   <= gate_d;
            busy        <= busy_d;
        end
    end
endmodule
